// File: rtl/fb_stream_reader_if.sv
// Memory read-port and AXI-Stream pixel bundle for fb_stream_reader.
// master = the reader (issues reads, sources pixels); slave = memory + scan-out side.
interface fb_stream_reader_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  o_Mem_Rd_En;
  logic [ADDR_WIDTH-1:0] o_Mem_Addr;
  logic                  i_Mem_Rd_Valid;
  logic [15:0]           i_Mem_Rd_Data;
  logic [15:0]           m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport master (
    output o_Mem_Rd_En,
    output o_Mem_Addr,
    input  i_Mem_Rd_Valid,
    input  i_Mem_Rd_Data,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );

  modport slave (
    input  o_Mem_Rd_En,
    input  o_Mem_Addr,
    output i_Mem_Rd_Valid,
    output i_Mem_Rd_Data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );
endinterface

// File: rtl/fb_stream_reader.sv
// Frame-sync triggered raster reader: memory reads -> show-ahead FIFO -> AXI-Stream pixels.
// First read one cycle after Fsync; reads are credit-limited so sink backpressure only pauses reads.

// Show-ahead FIFO with synchronous clear; head data is valid whenever o_count is non-zero.
module fb_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_wr_vld,
  input  logic [WIDTH-1:0]           i_wr_dat,
  input  logic                       i_rd_rdy,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push   = i_wr_vld;
  assign w_pop    = i_rd_rdy && (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  // The read-credit rule upstream is what keeps this from ever firing.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (!(w_push && !w_pop && !i_clr && (r_count == CW'(DEPTH))));
  end
endmodule

module fb_stream_reader #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Fsync,
  fb_stream_reader_if.master  bus,
  output logic                o_Busy
);
  localparam int NPIX = H_PIXELS * V_LINES;
  localparam int RCW  = $clog2(NPIX + 1);
  localparam int XW   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [RCW-1:0] r_rd_cnt;
  logic [FCW-1:0] r_in_flight;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;

  logic           w_rd_en;
  logic           w_tvalid;
  logic           w_ret;
  logic           w_push;
  logic           w_pop;
  logic           w_abort;
  logic           w_restart;
  logic           w_last_rd;
  logic [FCW:0]   w_committed;
  logic [FCW-1:0] w_fifo_cnt;
  logic [15:0]    w_head;

  // Returns are only meaningful while something is outstanding; strays after reset are dropped.
  assign w_ret       = bus.i_Mem_Rd_Valid && (r_in_flight != '0);
  assign w_committed = {1'b0, r_in_flight} + {1'b0, w_fifo_cnt};
  assign w_abort     = i_Fsync && ((r_state == RUN) || (r_state == DRAIN));
  assign w_restart   = ((r_state == IDLE) && i_Fsync) || w_abort;
  assign w_push      = w_ret && (r_state != FLUSH);
  assign w_pop       = w_tvalid && bus.m_axis_tready;
  assign w_last_rd   = w_rd_en && (r_rd_cnt == RCW'(NPIX - 1));

  fb_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_Clock),
    .i_rst    (i_Reset),
    .i_clr    (w_abort),
    .i_wr_vld (w_push),
    .i_wr_dat (bus.i_Mem_Rd_Data),
    .i_rd_rdy (w_pop),
    .o_rd_dat (w_head),
    .o_count  (w_fifo_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_tvalid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_Fsync) w_state_nxt = RUN;
      end
      RUN: begin
        w_rd_en  = (w_committed < (FCW+1)'(FIFO_DEPTH));
        w_tvalid = (w_fifo_cnt != '0);
        if (i_Fsync)        w_state_nxt = FLUSH;
        else if (w_last_rd) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_tvalid = (w_fifo_cnt != '0);
        if (i_Fsync)                                    w_state_nxt = FLUSH;
        else if ((w_fifo_cnt == '0) && (r_in_flight == '0)) w_state_nxt = IDLE;
      end
      FLUSH: begin
        if (!i_Fsync && (r_in_flight == '0)) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_rd_cnt    <= '0;
      r_in_flight <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_restart)    r_rd_cnt <= '0;
      else if (w_rd_en) r_rd_cnt <= r_rd_cnt + RCW'(1);

      if (w_rd_en && !w_ret)      r_in_flight <= r_in_flight + FCW'(1);
      else if (!w_rd_en && w_ret) r_in_flight <= r_in_flight - FCW'(1);

      if (w_restart) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_pop) begin
        if (r_x == XW'(H_PIXELS - 1)) begin
          r_x <= '0;
          r_y <= (r_y == YW'(V_LINES - 1)) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  assign bus.o_Mem_Rd_En   = w_rd_en;
  assign bus.o_Mem_Addr    = w_rd_en ? (BASE + ADDR_WIDTH'(r_rd_cnt)) : '0;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tdata  = w_tvalid ? w_head : 16'h0000;
  assign bus.m_axis_tlast  = w_tvalid && (r_x == XW'(H_PIXELS - 1));
  assign bus.m_axis_tuser  = w_tvalid && (r_x == '0) && (r_y == '0);
  assign o_Busy            = (r_state != IDLE);
endmodule

// File: tb/tb_fb_stream_reader.sv
// Bench for fb_stream_reader: a latency-randomized in-order memory and a random-ready sink,
// checked against a frame-level model of expected read addresses and pixel beats.
module tb_fb_stream_reader;
  localparam int H     = 8;
  localparam int V     = 4;
  localparam int N     = H * V;
  localparam int AW    = 8;
  localparam int BASE  = 240;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic fsync;
  logic busy;

  always #5 clk = ~clk;

  fb_stream_reader_if #(.ADDR_WIDTH(AW)) bus ();

  fb_stream_reader #(
    .H_PIXELS   (H),
    .V_LINES    (V),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .i_Fsync (fsync),
    .bus     (bus),
    .o_Busy  (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  req_t        mq[$];
  int          rd_cyc[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          rdy_pct = 100;
  int          exp_rd = N;
  int          exp_pix = N;
  int          reads_f = 0;
  int          beats_f = 0;
  int          tlast_cnt = 0;
  int          fs_cyc = 0;
  int          last_beat_cyc = 0;
  bit          stalled = 1'b0;
  bit          abort_prev = 1'b0;
  bit          active = 1'b0;
  logic [15:0] held_dat;
  logic        held_last;
  logic        held_user;

  // Memory contents: a distinct value per word address.
  function automatic logic [15:0] memf(input logic [AW-1:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  function automatic logic [AW-1:0] addr_of(input int idx);
    return AW'((BASE + idx) % (1 << AW));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then score this cycle's outputs.
  task automatic step(input bit fs);
    int due;
    bit rd;
    bit tv;
    @(negedge clk);
    cyc++;
    fsync = fs;
    bus.m_axis_tready = (int'($urandom_range(99, 0)) < rdy_pct);
    if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
      bus.i_Mem_Rd_Valid = 1'b1;
      bus.i_Mem_Rd_Data  = memf(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.i_Mem_Rd_Valid = 1'b0;
      bus.i_Mem_Rd_Data  = 16'h0000;
    end
    #1;
    rd = bus.o_Mem_Rd_En;
    tv = bus.m_axis_tvalid;
    if (abort_prev) chk("abort_tvalid", tv, 0);
    abort_prev = 1'b0;
    if (rd) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{bus.o_Mem_Addr, due});
      chk("rd_in_frame", exp_rd < N, 1);
      chk("rd_addr", bus.o_Mem_Addr, addr_of(exp_rd));
      rd_cyc.push_back(cyc);
      exp_rd++;
      reads_f++;
      chk("credit", (reads_f - beats_f) <= DEPTH, 1);
    end
    if (stalled) begin
      chk("hold_valid", tv, 1);
      chk("hold_data", bus.m_axis_tdata, held_dat);
      chk("hold_last", bus.m_axis_tlast, held_last);
      chk("hold_user", bus.m_axis_tuser, held_user);
    end
    stalled = 1'b0;
    if (tv && bus.m_axis_tready) begin
      chk("beat_in_frame", exp_pix < N, 1);
      chk("beat_data", bus.m_axis_tdata, memf(addr_of(exp_pix)));
      chk("beat_tuser", bus.m_axis_tuser, exp_pix == 0);
      chk("beat_tlast", bus.m_axis_tlast, (exp_pix % H) == (H - 1));
      if (bus.m_axis_tlast) tlast_cnt++;
      exp_pix++;
      beats_f++;
      last_beat_cyc = cyc;
      if (exp_pix >= N) active = 1'b0;
    end else if (tv && !fs) begin
      stalled   = 1'b1;
      held_dat  = bus.m_axis_tdata;
      held_last = bus.m_axis_tlast;
      held_user = bus.m_axis_tuser;
    end
    if (fs) begin
      abort_prev = active;
      active     = 1'b1;
      exp_rd     = 0;
      exp_pix    = 0;
      reads_f    = 0;
      beats_f    = 0;
      tlast_cnt  = 0;
      fs_cyc     = cyc;
      stalled    = 1'b0;
      rd_cyc.delete();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_en"}, bus.o_Mem_Rd_En, 0);
    chk({tag, "_addr"}, bus.o_Mem_Addr, 0);
    chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    chk({tag, "_tdata"}, bus.m_axis_tdata, 0);
    chk({tag, "_tlast"}, bus.m_axis_tlast, 0);
    chk({tag, "_tuser"}, bus.m_axis_tuser, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_until_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (!((exp_pix == N) && !busy) && (n < maxc)) begin
      step(1'b0);
      n++;
    end
    chk({tag, "_beats"}, exp_pix, N);
    chk({tag, "_reads"}, exp_rd, N);
    chk({tag, "_tlast_count"}, tlast_cnt, V);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_busy_fall"}, (cyc - last_beat_cyc) <= 2, 1);
  endtask

  initial begin
    int n;
    rst                = 1'b1;
    fsync              = 1'b0;
    bus.m_axis_tready  = 1'b0;
    bus.i_Mem_Rd_Valid = 1'b0;
    bus.i_Mem_Rd_Data  = 16'h0000;
    #2;
    chk_quiet("reset");
    rst = 1'b0;
    repeat (3) step(1'b0);
    chk("idle_busy", busy, 0);

    // 1: latency 1, sink always ready -> back-to-back reads from the cycle after Fsync.
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    step(1'b1);
    run_until_idle(200, "t1");
    chk("t1_read_count", rd_cyc.size(), N);
    if (rd_cyc.size() == N) begin
      chk("t1_first_rd", rd_cyc[0], fs_cyc + 1);
      for (int i = 1; i < N; i++) chk("t1_b2b", rd_cyc[i] - rd_cyc[i-1], 1);
    end

    // 2: latency 5 with sink stalled -> exactly DEPTH reads, then held output.
    lat_lo = 5; lat_hi = 5; rdy_pct = 0;
    step(1'b1);
    repeat (20) step(1'b0);
    chk("t2_stalled_reads", reads_f, DEPTH);
    chk("t2_tvalid", bus.m_axis_tvalid, 1);
    rdy_pct = 100;
    run_until_idle(400, "t2");

    // 3: abort after beat 3 with reads outstanding; restart from pixel 0.
    lat_lo = 5; lat_hi = 5; rdy_pct = 100;
    step(1'b1);
    n = 0;
    while ((exp_pix < 4) && (n < 100)) begin
      step(1'b0);
      n++;
    end
    chk("t3_reached_beat3", exp_pix, 4);
    step(1'b1);
    run_until_idle(400, "t3");

    // 5: reset mid-frame; stale returns must be ignored, then a clean frame.
    lat_lo = 1; lat_hi = 8; rdy_pct = 50;
    step(1'b1);
    repeat (10) step(1'b0);
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    exp_rd = N; exp_pix = N; active = 1'b0; stalled = 1'b0; abort_prev = 1'b0;
    repeat (2) step(1'b0);
    rst = 1'b0;
    n = 0;
    while ((mq.size() > 0) && (n < 60)) begin
      step(1'b0);
      n++;
    end
    repeat (3) step(1'b0);
    chk_quiet("post_rst");
    step(1'b1);
    run_until_idle(1000, "t5");

    // 6: Fsync again while flushing -> a single restart.
    lat_lo = 8; lat_hi = 8; rdy_pct = 100;
    step(1'b1);
    repeat (6) step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    run_until_idle(600, "t6");

    // 4: random latency and ready over several frames.
    lat_lo = 1; lat_hi = 8; rdy_pct = 50;
    for (int f = 0; f < 6; f++) begin
      step(1'b1);
      run_until_idle(2000, "t4");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
